sfft_sample_scheduler: RTL

//  Paces audio samples into SFFT_Pipeline. Buffers codec samples in a small FIFO and issues

---
 rtl/sfft_sample_scheduler.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/sfft_sample_scheduler.sv
// Paces codec samples into SFFT_Pipeline through a small FIFO and rate-limited advance strobes,
// and tracks completed FFT frames with a sticky ready flag and saturating loss counters.
module sfft_sample_scheduler #(
  parameter int INPUT_WIDTH = 24,
  parameter int FIFO_DEPTH  = 4,
  parameter int MIN_GAP     = 33,
  parameter int GAP_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INPUT_WIDTH-1:0] sample_in,
  input  logic                   sample_valid,
  input  logic                   enable,
  output logic [INPUT_WIDTH-1:0] SampleAmplitudeOut,
  output logic                   advanceSignal,
  input  logic                   OutputValid,
  output logic                   frame_ready,
  input  logic                   frame_ack,
  output logic [15:0]            frame_count,
  output logic [7:0]             drop_count,
  output logic [7:0]             missed_count,
  output logic [1:0]             state_dbg
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 4);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] STROBE = 2'd2;
  localparam logic [1:0] GAP    = 2'd3;

  logic [INPUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [INPUT_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [1:0]             state_q, state_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic [INPUT_WIDTH-1:0] sample_out_q, sample_out_d;
  logic                   advance_q, advance_d;
  logic                   frame_ready_q, frame_ready_d;
  logic [15:0]            frame_count_q, frame_count_d;
  logic [7:0]             drop_count_q, drop_count_d;
  logic [7:0]             missed_count_q, missed_count_d;

  logic empty, full, pop, push, drop;

  // A pop can only happen from IDLE, so a full FIFO still takes a sample on that cycle.
  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == DEPTH_C);
    pop   = (state_q == IDLE) && enable && !empty;
    push  = sample_valid && (!full || pop);
    drop  = sample_valid && full && !pop;

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = sample_in;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    drop_count_d = (drop && drop_count_q != 8'hFF) ? drop_count_q + 8'd1 : drop_count_q;
  end

  // Strobe-to-strobe period is STROBE + (MIN_GAP-3) GAP cycles + IDLE + LOAD = MIN_GAP.
  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    sample_out_d = sample_out_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          sample_out_d = mem_q[rd_ptr_q];
          state_d      = LOAD;
        end
      end
      LOAD:   state_d = STROBE;
      STROBE: begin
        gap_cnt_d = GAP_LOAD;
        state_d   = GAP;
      end
      GAP: begin
        if (gap_cnt_q == '0) state_d = IDLE;
        else                 gap_cnt_d = gap_cnt_q - GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
    advance_d = (state_d == STROBE);
  end

  // A simultaneous frame_ack loses to OutputValid and also suppresses the miss count.
  always_comb begin
    frame_ready_d  = frame_ready_q;
    frame_count_d  = frame_count_q;
    missed_count_d = missed_count_q;
    if (OutputValid) begin
      frame_ready_d = 1'b1;
      frame_count_d = frame_count_q + 16'd1;
      if (frame_ready_q && !frame_ack && missed_count_q != 8'hFF)
        missed_count_d = missed_count_q + 8'd1;
    end else if (frame_ack) begin
      frame_ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      state_q        <= IDLE;
      gap_cnt_q      <= '0;
      sample_out_q   <= '0;
      advance_q      <= 1'b0;
      frame_ready_q  <= 1'b0;
      frame_count_q  <= '0;
      drop_count_q   <= '0;
      missed_count_q <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      state_q        <= state_d;
      gap_cnt_q      <= gap_cnt_d;
      sample_out_q   <= sample_out_d;
      advance_q      <= advance_d;
      frame_ready_q  <= frame_ready_d;
      frame_count_q  <= frame_count_d;
      drop_count_q   <= drop_count_d;
      missed_count_q <= missed_count_d;
    end
  end

  assign SampleAmplitudeOut = sample_out_q;
  assign advanceSignal      = advance_q;
  assign frame_ready        = frame_ready_q;
  assign frame_count        = frame_count_q;
  assign drop_count         = drop_count_q;
  assign missed_count       = missed_count_q;
  assign state_dbg          = state_q;

endmodule
